exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Parametrised instruction-cycle control sequencer for the tinycpu core: the successor to the fixed 3-bit run/cont/halt state block.
- Steps through NPHASE execution phases per instruction and adds single-step mode, deferred halt, and an instruction-retire counter.
- Drives phase enables to the datapath; the debug/console logic drives its run/halt/cont/step inputs.

Parameters:
- NPHASE, 4, phases per instruction cycle; legal range 2..8.
- PW, 3, width of cs phase code; 2^PW >= NPHASE+1 required.
- CNTW, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start execution from IDLE.
- halt  in  1  request stop at end of current instruction.
- cont  in  1  resume continuous execution from HALTED.
- step  in  1  execute exactly one instruction from HALTED.
- cs  out  PW  phase code: 0 = not executing; k+1 = phase k (1..NPHASE).
- phase  out  NPHASE  one-hot phase enable; bit k high in phase k; all zero outside EXEC.
- running  out  1  high in EXEC.
- halted  out  1  high in HALTED.
- retire  out  1  high during the last phase (NPHASE-1) of each instruction.
- icount  out  CNTW  count of retired instructions.

Behaviour:
- States: IDLE, EXEC (phase index 0..NPHASE-1), HALTED. Internal flags: halt_pend, step_mode.
- All outputs are Moore-decoded from registered state/phase. icount is a register.
- Reset (reset=0, asynchronous): IDLE, phase index 0, halt_pend=0, step_mode=0, icount=0. Outputs: cs=0, phase=0, running=0, halted=0, retire=0. Reset asserted mid-instruction aborts immediately, no retire.
- IDLE:
  - run=1 at an edge -> EXEC phase 0 on the next cycle (cs=1).
  - halt, cont and step are ignored.
- EXEC:
  - Phase index increments by 1 each cycle.
  - In phase NPHASE-1: retire=1, icount increments at that edge and wraps modulo 2^CNTW.
  - halt=1 in any EXEC cycle sets halt_pend.
  - At the end of phase NPHASE-1: if halt_pend, halt=1 in that same cycle, or step_mode -> HALTED, clearing halt_pend and step_mode. Otherwise -> phase 0.
  - A halt is never taken mid-instruction.
  - run, cont and step are ignored in EXEC.
- HALTED:
  - cs=0, phase=0, halted=1.
  - cont=1 -> EXEC phase 0, step_mode=0.
  - step=1 with cont=0 -> EXEC phase 0, step_mode=1. The instruction runs all NPHASE phases, then returns to HALTED.
  - cont and step asserted together: cont wins (continuous run).
  - run and halt are ignored in HALTED.
- There is no return path to IDLE except reset.
- Inputs are level-sampled each edge. A held input acts once per qualifying state entry; e.g. cont held high in HALTED keeps re-entering EXEC after each halt.
- Latency: run/cont/step to first phase = 1 cycle. halt request to halted = remaining phases of the current instruction + 1.

Test Plan (NPHASE=4, PW=3, CNTW=16 unless noted):
- Reset and release: hold reset=0 with run=1 -> cs=0, phase=0, running=0, halted=0, icount=0; no activity until reset=1.
- Continuous run: release reset, pulse run for 1 cycle -> cs sequence 1,2,3,4,1,2,3,4,1,2,3,4; phase 0001,0010,0100,1000 repeating; retire high when cs=4; icount=3 after 12 cycles.
- Deferred halt: pulse halt when cs=2 -> cs=3 then cs=4 (retire), then halted=1, cs=0; icount increments by exactly 1 after the halt pulse.
- Halt in last phase: halt=1 when cs=4 -> HALTED on the next cycle. Then pulse cont -> cs=1 next cycle, running=1, continuous again.
- Single step: in HALTED, pulse step -> exactly cs 1,2,3,4 with one retire, then halted=1. Assert step and cont together in HALTED -> continuous run with no auto-halt.
- Wrap and abort: CNTW=4, retire 16 instructions -> icount=0. Assert reset=0 while cs=3 -> all outputs 0 immediately, before any clock edge; icount=0.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Console/debug <-> sequencer bundle: run-control requests in, phase/status out.
// The master side is the console; the sequencer is the slave.
interface exec_sequencer_if #(
  parameter int NPHASE = 4,
  parameter int PW     = 3,
  parameter int CNTW   = 16
);
  logic              run;
  logic              halt;
  logic              cont;
  logic              step;
  logic [PW-1:0]     cs;
  logic [NPHASE-1:0] phase;
  logic              running;
  logic              halted;
  logic              retire;
  logic [CNTW-1:0]   icount;

  modport master (
    output run, halt, cont, step,
    input  cs, phase, running, halted, retire, icount
  );

  modport slave (
    input  run, halt, cont, step,
    output cs, phase, running, halted, retire, icount
  );
endinterface

// File: rtl/exec_sequencer.sv
// tinycpu instruction-cycle sequencer: NPHASE phases per instruction, with
// deferred halt, single-step and a wrapping retired-instruction counter.
module exec_sequencer #(
  parameter int NPHASE = 4,
  parameter int PW     = 3,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  exec_sequencer_if.slave  bus
);

  localparam logic [1:0]    ST_IDLE   = 2'd0;
  localparam logic [1:0]    ST_EXEC   = 2'd1;
  localparam logic [1:0]    ST_HALTED = 2'd2;
  localparam logic [PW-1:0] LAST_PH   = PW'(NPHASE - 1);

  logic [1:0]      r_state;
  logic [PW-1:0]   r_phIdx;
  logic            r_haltPend;
  logic            r_stepMode;
  logic [CNTW-1:0] r_icount;

  logic w_exec;
  logic w_last;
  logic w_stopNow;

  assign w_exec    = (r_state == ST_EXEC);
  assign w_last    = w_exec && (r_phIdx == LAST_PH);
  // A halt raised in the final phase itself still stops at this boundary.
  assign w_stopNow = r_haltPend | bus.halt | r_stepMode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_phIdx    <= '0;
      r_haltPend <= 1'b0;
      r_stepMode <= 1'b0;
      r_icount   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.run) begin
            r_state <= ST_EXEC;
            r_phIdx <= '0;
          end
        end
        ST_EXEC: begin
          if (bus.halt) r_haltPend <= 1'b1;
          if (w_last) begin
            r_icount <= r_icount + CNTW'(1);
            r_phIdx  <= '0;
            if (w_stopNow) begin
              r_state    <= ST_HALTED;
              r_haltPend <= 1'b0;
              r_stepMode <= 1'b0;
            end
          end else begin
            r_phIdx <= r_phIdx + PW'(1);
          end
        end
        ST_HALTED: begin
          // cont takes priority over step when both are requested.
          if (bus.cont) begin
            r_state    <= ST_EXEC;
            r_phIdx    <= '0;
            r_stepMode <= 1'b0;
          end else if (bus.step) begin
            r_state    <= ST_EXEC;
            r_phIdx    <= '0;
            r_stepMode <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_phIdx <= '0;
        end
      endcase
    end
  end

  assign bus.cs      = w_exec ? (r_phIdx + PW'(1)) : '0;
  assign bus.phase   = w_exec ? (NPHASE'(1) << r_phIdx) : '0;
  assign bus.running = w_exec;
  assign bus.halted  = (r_state == ST_HALTED);
  assign bus.retire  = w_last;
  assign bus.icount  = r_icount;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised scoreboard bench for exec_sequencer; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_exec_sequencer;

  localparam int NPHASE = 4;
  localparam int PW     = 3;
  localparam int CNTW   = 16;
  localparam int CNTW_S = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  exec_sequencer_if #(.NPHASE(NPHASE), .PW(PW), .CNTW(CNTW))   busA ();
  exec_sequencer_if #(.NPHASE(NPHASE), .PW(PW), .CNTW(CNTW_S)) busB ();

  exec_sequencer #(.NPHASE(NPHASE), .PW(PW), .CNTW(CNTW)) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );
  exec_sequencer #(.NPHASE(NPHASE), .PW(PW), .CNTW(CNTW_S)) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  typedef struct {
    logic [PW-1:0]     cs;
    logic [NPHASE-1:0] phase;
    logic              running;
    logic              halted;
    logic              retire;
    logic [CNTW-1:0]   icount;
    logic [CNTW_S-1:0] icountS;
  } expT;

  expT expQ[$];
  int  nCompared = 0;
  int  nFailed   = 0;

  // Reference model: "inside an instruction at phase mPhase", "halted", or neither (idle).
  bit mInInstr, mHalted, mStopReq, mSingle;
  int mPhase, mRetired;

  function automatic void modelReset();
    mInInstr = 0; mHalted = 0; mStopReq = 0; mSingle = 0;
    mPhase = 0; mRetired = 0;
  endfunction

  function automatic void modelEdge(bit r, bit h, bit c, bit s);
    if (mInInstr) begin
      if (h) mStopReq = 1;
      if (mPhase == NPHASE - 1) begin
        mRetired++;
        mPhase = 0;
        if (mStopReq || mSingle) begin
          mInInstr = 0; mHalted = 1; mStopReq = 0; mSingle = 0;
        end
      end else begin
        mPhase++;
      end
    end else if (mHalted) begin
      if (c || s) begin
        mHalted = 0; mInInstr = 1; mPhase = 0; mSingle = !c;
      end
    end else if (r) begin
      mInInstr = 1; mPhase = 0;
    end
  endfunction

  function automatic expT modelView();
    expT e;
    e.cs      = mInInstr ? PW'(mPhase + 1) : '0;
    e.phase   = mInInstr ? (NPHASE'(1) << mPhase) : '0;
    e.running = mInInstr;
    e.halted  = mHalted;
    e.retire  = mInInstr && (mPhase == NPHASE - 1);
    e.icount  = CNTW'(mRetired);
    e.icountS = CNTW_S'(mRetired);
    return e;
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input expT e);
    compare("cs",      32'(busA.cs),      32'(e.cs));
    compare("phase",   32'(busA.phase),   32'(e.phase));
    compare("running", 32'(busA.running), 32'(e.running));
    compare("halted",  32'(busA.halted),  32'(e.halted));
    compare("retire",  32'(busA.retire),  32'(e.retire));
    compare("icount",  32'(busA.icount),  32'(e.icount));
    compare("csSmall", 32'(busB.cs),      32'(e.cs));
    compare("icount4", 32'(busB.icount),  32'(e.icountS));
  endtask

  task automatic applyStimulus(input bit rst, input bit r, input bit h, input bit c, input bit s);
    @(negedge clk);
    reset = rst;
    busA.run = r; busA.halt = h; busA.cont = c; busA.step = s;
    busB.run = r; busB.halt = h; busB.cont = c; busB.step = s;
    if (!rst) modelReset();
    else      modelEdge(r, h, c, s);
    expQ.push_back(modelView());
  endtask

  task automatic waitForCs(input int want);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mInInstr && (mPhase + 1 == want)) found = 1;
      else applyStimulus(1, 0, 0, 0, 0);
    end
    compare("waitCs", 32'(found), 32'd1);
  endtask

  // Monitor: one expected snapshot per clock, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    reset = 1'b0;
    busA.run = 0; busA.halt = 0; busA.cont = 0; busA.step = 0;
    busB.run = 0; busB.halt = 0; busB.cont = 0; busB.step = 0;
    modelReset();

    $display("[TB] reset held with run asserted");
    repeat (3) applyStimulus(0, 1, 0, 0, 0);

    $display("[TB] continuous run");
    applyStimulus(1, 1, 0, 0, 0);
    repeat (12) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] deferred halt");
    waitForCs(2);
    applyStimulus(1, 0, 1, 0, 0);
    repeat (4) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] halt in last phase, then cont");
    applyStimulus(1, 0, 0, 1, 0);
    waitForCs(4);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    repeat (6) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] single step and step+cont");
    waitForCs(2);
    applyStimulus(1, 0, 1, 0, 0);
    repeat (4) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    repeat (6) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1);
    repeat (12) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] long run for counter wrap");
    repeat (70) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 299) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0);
    end

    $display("[TB] asynchronous abort mid-instruction");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    repeat (6) applyStimulus(1, 0, 0, 0, 0);
    waitForCs(3);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    compare("abortCs",      32'(busA.cs),      32'd0);
    compare("abortPhase",   32'(busA.phase),   32'd0);
    compare("abortRunning", 32'(busA.running), 32'd0);
    compare("abortHalted",  32'(busA.halted),  32'd0);
    compare("abortRetire",  32'(busA.retire),  32'd0);
    compare("abortIcount",  32'(busA.icount),  32'd0);
    applyStimulus(0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    compare("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
